// File: rtl/sprite_spawner.sv
// Sprite spawn controller: debounced button -> latched position/variant, frame-paced show/cooldown.
// Optional macro SPRITE_SPAWNER_AUTO_EN adds an automatic spawn after AUTO_FRAMES idle frames.
module sprite_spawner #(
  parameter int unsigned SCREEN_W        = 1280,
  parameter int unsigned SCREEN_H        = 720,
  parameter int unsigned SPRITE_W        = 256,
  parameter int unsigned SPRITE_H        = 256,
  parameter int unsigned SHOW_FRAMES     = 60,
  parameter int unsigned COOLDOWN_FRAMES = 15,
  parameter int unsigned DEBOUNCE_CYCLES = 742500,
  parameter int unsigned AUTO_FRAMES     = 120
) (
  input  logic        clk_pixel_in,
  input  logic        rst_in,
  input  logic        trigger_in,
  input  logic [15:0] rand_in,
  input  logic        nf_in,
  output logic [10:0] x_out,
  output logic [9:0]  y_out,
  output logic        pop_out,
  output logic        visible_out,
  output logic        busy_out,
  output logic [7:0]  spawn_count_out
);

  localparam logic [10:0] XMAX = 11'(SCREEN_W - SPRITE_W);
  localparam logic [9:0]  YMAX = 10'(SCREEN_H - SPRITE_H);

  localparam int unsigned MAXF_A = (SHOW_FRAMES > COOLDOWN_FRAMES) ? SHOW_FRAMES : COOLDOWN_FRAMES;
  localparam int unsigned MAXF   = (MAXF_A > AUTO_FRAMES) ? MAXF_A : AUTO_FRAMES;
  localparam int unsigned FCW    = $clog2(MAXF + 1);
  localparam int unsigned DBW    = $clog2(DEBOUNCE_CYCLES + 1);

  typedef enum logic [1:0] {StIdle, StSpawn, StShow, StCooldown} state_e;

  // Input conditioning
  logic           sync1_q, sync2_q, deb_q, deb_prev_q;
  logic [DBW-1:0] deb_cnt_q;
  logic           trig_pulse;

  always_ff @(posedge clk_pixel_in) begin
    if (rst_in) begin
      sync1_q    <= 1'b0;
      sync2_q    <= 1'b0;
      deb_q      <= 1'b0;
      deb_prev_q <= 1'b0;
      deb_cnt_q  <= '0;
    end else begin
      sync1_q    <= trigger_in;
      sync2_q    <= sync1_q;
      deb_prev_q <= deb_q;
      if (sync2_q == deb_q) begin
        deb_cnt_q <= '0;
      end else if (deb_cnt_q == DBW'(DEBOUNCE_CYCLES - 1)) begin
        deb_q     <= sync2_q;
        deb_cnt_q <= '0;
      end else begin
        deb_cnt_q <= deb_cnt_q + 1'b1;
      end
    end
  end

  assign trig_pulse = deb_q & ~deb_prev_q;

  // Spawn FSM
  state_e         state_q, state_d;
  logic [FCW-1:0] frame_q, frame_d;
  logic [10:0]    x_q, x_d;
  logic [9:0]     y_q, y_d;
  logic           pop_q, pop_d;
  logic [7:0]     count_q, count_d;
  logic           visible_q, visible_d;
  logic           busy_q, busy_d;
  logic           auto_fire;
  logic [10:0]    x_raw;
  logic [9:0]     y_raw;

  assign x_raw = rand_in[10:0];
  assign y_raw = rand_in[15:6];

`ifdef SPRITE_SPAWNER_AUTO_EN
  logic [FCW-1:0] idle_q, idle_d;

  assign auto_fire = (state_q == StIdle) && nf_in && (idle_q == FCW'(AUTO_FRAMES - 1));

  always_comb begin
    idle_d = idle_q;
    if (state_d != StIdle) begin
      idle_d = '0;
    end else if (nf_in) begin
      idle_d = idle_q + 1'b1;
    end
  end

  always_ff @(posedge clk_pixel_in) begin
    if (rst_in) idle_q <= '0;
    else        idle_q <= idle_d;
  end
`else
  assign auto_fire = 1'b0;
`endif

  always_comb begin
    state_d   = state_q;
    frame_d   = frame_q;
    x_d       = x_q;
    y_d       = y_q;
    pop_d     = pop_q;
    count_d   = count_q;
    visible_d = (state_q == StShow);
    busy_d    = (state_q == StShow) || (state_q == StCooldown);
    case (state_q)
      StIdle: begin
        if (trig_pulse || auto_fire) state_d = StSpawn;
      end
      StSpawn: begin
        x_d     = (x_raw > XMAX) ? XMAX : x_raw;
        y_d     = (y_raw > YMAX) ? YMAX : y_raw;
        pop_d   = rand_in[0];
        frame_d = '0;
        if (count_q != 8'hFF) count_d = count_q + 8'd1;
        state_d = StShow;
      end
      StShow: begin
        // Retrigger takes priority over a coincident frame tick.
        if (trig_pulse) begin
          state_d = StSpawn;
        end else if (nf_in) begin
          if (frame_q == FCW'(SHOW_FRAMES - 1)) begin
            state_d = StCooldown;
            frame_d = '0;
          end else begin
            frame_d = frame_q + 1'b1;
          end
        end
      end
      StCooldown: begin
        if (nf_in) begin
          if (frame_q == FCW'(COOLDOWN_FRAMES - 1)) begin
            state_d = StIdle;
            frame_d = '0;
          end else begin
            frame_d = frame_q + 1'b1;
          end
        end
      end
      default: state_d = StIdle;
    endcase
  end

  always_ff @(posedge clk_pixel_in) begin
    if (rst_in) begin
      state_q   <= StIdle;
      frame_q   <= '0;
      x_q       <= '0;
      y_q       <= '0;
      pop_q     <= 1'b0;
      count_q   <= '0;
      visible_q <= 1'b0;
      busy_q    <= 1'b0;
    end else begin
      state_q   <= state_d;
      frame_q   <= frame_d;
      x_q       <= x_d;
      y_q       <= y_d;
      pop_q     <= pop_d;
      count_q   <= count_d;
      visible_q <= visible_d;
      busy_q    <= busy_d;
    end
  end

  assign x_out           = x_q;
  assign y_out           = y_q;
  assign pop_out         = pop_q;
  assign visible_out     = visible_q;
  assign busy_out        = busy_q;
  assign spawn_count_out = count_q;

endmodule

// File: tb/tb_sprite_spawner.sv
// Directed self-checking bench for sprite_spawner with short debounce and frame parameters.
module tb_sprite_spawner;

  localparam int unsigned DEB = 4;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        trigger = 1'b0;
  logic [15:0] rand_w = 16'h0000;
  logic        nf = 1'b0;
  logic [10:0] x;
  logic [9:0]  y;
  logic        pop, visible, busy;
  logic [7:0]  spawn_count;

  int n_checks = 0;
  int n_errors = 0;

  sprite_spawner #(
    .SCREEN_W        (1280),
    .SCREEN_H        (720),
    .SPRITE_W        (256),
    .SPRITE_H        (256),
    .SHOW_FRAMES     (3),
    .COOLDOWN_FRAMES (2),
    .DEBOUNCE_CYCLES (DEB),
    .AUTO_FRAMES     (4)
  ) dut (
    .clk_pixel_in    (clk),
    .rst_in          (rst),
    .trigger_in      (trigger),
    .rand_in         (rand_w),
    .nf_in           (nf),
    .x_out           (x),
    .y_out           (y),
    .pop_out         (pop),
    .visible_out     (visible),
    .busy_out        (busy),
    .spawn_count_out (spawn_count)
  );

  always #5 clk = ~clk;

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0d, expected %0d", tag, got, exp);
    end
  endtask

  task automatic cycles(input int n);
    repeat (n) @(posedge clk);
    @(negedge clk);
  endtask

  // One new-frame pulse followed by 99 quiet cycles.
  task automatic frame_tick();
    @(negedge clk);
    nf = 1'b1;
    @(negedge clk);
    nf = 1'b0;
    cycles(98);
  endtask

  task automatic press(input int hold);
    @(negedge clk);
    trigger = 1'b1;
    cycles(hold);
    trigger = 1'b0;
    cycles(DEB + 10);
  endtask

  task automatic check_all_zero(input string tag);
    check_eq({tag, "_x"}, 32'(x), 0);
    check_eq({tag, "_y"}, 32'(y), 0);
    check_eq({tag, "_pop"}, 32'(pop), 0);
    check_eq({tag, "_vis"}, 32'(visible), 0);
    check_eq({tag, "_busy"}, 32'(busy), 0);
    check_eq({tag, "_cnt"}, 32'(spawn_count), 0);
  endtask

  initial begin
    int lat;
    cycles(3);
    check_all_zero("reset");
    rst = 1'b0;
    cycles(2);

    // Glitch shorter than the debounce window is filtered.
    @(negedge clk);
    trigger = 1'b1;
    cycles(3);
    trigger = 1'b0;
    cycles(20);
    check_eq("glitch_vis", 32'(visible), 0);
    check_eq("glitch_cnt", 32'(spawn_count), 0);
    check_eq("glitch_busy", 32'(busy), 0);

    // Latency from first sampling edge of trigger to visible rise.
    rand_w = 16'h0123;
    @(negedge clk);
    trigger = 1'b1;
    @(posedge clk);
    lat = 0;
    while (lat < 50) begin
      @(posedge clk);
      lat++;
      #1;
      if (visible) break;
    end
    check_eq("latency", 32'(lat), DEB + 4);
    cycles(12);
    trigger = 1'b0;
    cycles(DEB + 10);
    check_eq("t1_x", 32'(x), 291);
    check_eq("t1_y", 32'(y), 4);
    check_eq("t1_pop", 32'(pop), 1);
    check_eq("t1_cnt", 32'(spawn_count), 1);
    check_eq("t1_busy", 32'(busy), 1);

    // Show for 3 frames, then cooldown for 2; trigger in cooldown dropped.
    frame_tick();
    check_eq("f1_vis", 32'(visible), 1);
    frame_tick();
    check_eq("f2_vis", 32'(visible), 1);
    frame_tick();
    check_eq("f3_vis", 32'(visible), 0);
    check_eq("f3_busy", 32'(busy), 1);
    rand_w = 16'hFFFF;
    press(10);
    check_eq("cd_trig_cnt", 32'(spawn_count), 1);
    check_eq("cd_trig_x", 32'(x), 291);
    check_eq("cd_trig_vis", 32'(visible), 0);
    frame_tick();
    check_eq("cd1_busy", 32'(busy), 1);
    frame_tick();
    check_eq("cd2_busy", 32'(busy), 0);
    check_eq("cd2_vis", 32'(visible), 0);

    // Clamped spawn.
    press(10);
    check_eq("t2_x", 32'(x), 1024);
    check_eq("t2_y", 32'(y), 464);
    check_eq("t2_pop", 32'(pop), 1);
    check_eq("t2_cnt", 32'(spawn_count), 2);
    check_eq("t2_vis", 32'(visible), 1);

    // Retrigger after two frames restarts the show window.
    frame_tick();
    frame_tick();
    rand_w = 16'h0040;
    press(10);
    check_eq("rt_x", 32'(x), 64);
    check_eq("rt_y", 32'(y), 1);
    check_eq("rt_pop", 32'(pop), 0);
    check_eq("rt_cnt", 32'(spawn_count), 3);
    frame_tick();
    frame_tick();
    check_eq("rt_f2_vis", 32'(visible), 1);
    frame_tick();
    check_eq("rt_f3_vis", 32'(visible), 0);
    frame_tick();
    frame_tick();
    check_eq("rt_idle_busy", 32'(busy), 0);

    // Reset mid-show.
    press(10);
    frame_tick();
    check_eq("pre_rst_vis", 32'(visible), 1);
    check_eq("pre_rst_cnt", 32'(spawn_count), 4);
    rst = 1'b1;
    @(posedge clk);
    #1;
    check_all_zero("mid_rst");
    @(negedge clk);
    rst = 1'b0;
    cycles(2);

`ifdef SPRITE_SPAWNER_AUTO_EN
    frame_tick();
    frame_tick();
    frame_tick();
    check_eq("auto_pre_vis", 32'(visible), 0);
    frame_tick();
    check_eq("auto_vis", 32'(visible), 1);
    check_eq("auto_cnt", 32'(spawn_count), 1);
    check_eq("auto_x", 32'(x), 64);
`else
    repeat (5) frame_tick();
    check_eq("noauto_vis", 32'(visible), 0);
    check_eq("noauto_cnt", 32'(spawn_count), 0);
    check_eq("noauto_busy", 32'(busy), 0);
`endif

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
